// File: rtl/ascon_pack.sv
// ascon_pack
// Shared definitions for the Ascon substitution layer.
//   sbox_col_t     : one 5-bit state column (bit 4 = x0 ... bit 0 = x4)
//   SBOX_TABLE     : forward Ascon S-box, indexed by the input column
//   SBOX_INV_TABLE : inverse S-box, only present when SBOX_INV_EN is defined
// Configuration macro: SBOX_INV_EN
package ascon_pack;

  typedef logic [4:0] sbox_col_t;

  localparam sbox_col_t SBOX_TABLE [0:31] = '{
    5'h04, 5'h0B, 5'h1F, 5'h14, 5'h1A, 5'h15, 5'h09, 5'h02,
    5'h1B, 5'h05, 5'h08, 5'h12, 5'h1D, 5'h03, 5'h06, 5'h1C,
    5'h1E, 5'h13, 5'h07, 5'h0E, 5'h00, 5'h0D, 5'h11, 5'h18,
    5'h10, 5'h0C, 5'h01, 5'h19, 5'h16, 5'h0A, 5'h0F, 5'h17
  };

`ifdef SBOX_INV_EN
  localparam sbox_col_t SBOX_INV_TABLE [0:31] = '{
    5'h14, 5'h1A, 5'h07, 5'h0D, 5'h00, 5'h09, 5'h0E, 5'h12,
    5'h0A, 5'h06, 5'h1D, 5'h01, 5'h19, 5'h15, 5'h13, 5'h1E,
    5'h18, 5'h16, 5'h0B, 5'h11, 5'h03, 5'h05, 5'h1C, 5'h1F,
    5'h17, 5'h1B, 5'h04, 5'h08, 5'h0F, 5'h0C, 5'h10, 5'h02
  };
`endif

endpackage

// File: rtl/sbox.sv
// sbox
// One registered column slice of the Ascon substitution layer. The input
// column is looked up combinationally and the image is registered, giving
// a fixed one-cycle latency at one column per cycle.
// Ports:
//   clock_i  in   1  rising-edge clock
//   reset_i  in   1  synchronous active-high reset (clears sbox_o/valid_o)
//   valid_i  in   1  sbox_i carries a column this cycle
//   sbox_i   in   5  input column, bit 4 = x0 ... bit 0 = x4
//   inv_i    in   1  only with SBOX_INV_EN: 1 selects the inverse S-box
//   valid_o  out  1  sbox_o holds a fresh result
//   sbox_o   out  5  substituted column, same bit ordering as sbox_i
// Configuration macro: SBOX_INV_EN (adds inv_i and the inverse table)
module sbox
  import ascon_pack::*;
(
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       valid_i,
  input  logic [4:0] sbox_i,
`ifdef SBOX_INV_EN
  input  logic       inv_i,
`endif
  output logic       valid_o,
  output logic [4:0] sbox_o
);

  sbox_col_t w_sub;
  sbox_col_t r_sbox;
  logic      r_valid;

  // Table lookup ahead of the register; the inverse path only exists
  // in builds that ask for it.
  always_comb begin
    w_sub = SBOX_TABLE[sbox_i];
`ifdef SBOX_INV_EN
    if (inv_i) begin
      w_sub = SBOX_INV_TABLE[sbox_i];
    end
`endif
  end

  // Output register: reset wins over valid_i, and the data only updates
  // on valid columns so the last result stays visible between columns.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_sbox  <= 5'h00;
      r_valid <= 1'b0;
    end else begin
      r_valid <= valid_i;
      if (valid_i) begin
        r_sbox <= w_sub;
      end
    end
  end

  assign sbox_o  = r_sbox;
  assign valid_o = r_valid;

endmodule

// File: tb/tb_sbox.sv
// tb_sbox
// Directed bench for sbox: every driven cycle pushes its expected
// {valid_o, sbox_o} onto a scoreboard queue, which is popped and compared
// one clock later. Inverse-map steps are included when SBOX_INV_EN is set.
module tb_sbox;

  logic       clock;
  logic       reset;
  logic       validIn;
  logic [4:0] sboxIn;
  logic       invIn;
  logic       validOut;
  logic [4:0] sboxOut;

  int checks = 0;
  int errors = 0;

  // Reference tables written out independently of the design package.
  logic [4:0] fwdRef [0:31] = '{
    5'h04, 5'h0B, 5'h1F, 5'h14, 5'h1A, 5'h15, 5'h09, 5'h02,
    5'h1B, 5'h05, 5'h08, 5'h12, 5'h1D, 5'h03, 5'h06, 5'h1C,
    5'h1E, 5'h13, 5'h07, 5'h0E, 5'h00, 5'h0D, 5'h11, 5'h18,
    5'h10, 5'h0C, 5'h01, 5'h19, 5'h16, 5'h0A, 5'h0F, 5'h17
  };
  logic [4:0] invRef [0:31] = '{
    5'h14, 5'h1A, 5'h07, 5'h0D, 5'h00, 5'h09, 5'h0E, 5'h12,
    5'h0A, 5'h06, 5'h1D, 5'h01, 5'h19, 5'h15, 5'h13, 5'h1E,
    5'h18, 5'h16, 5'h0B, 5'h11, 5'h03, 5'h05, 5'h1C, 5'h1F,
    5'h17, 5'h1B, 5'h04, 5'h08, 5'h0F, 5'h0C, 5'h10, 5'h02
  };

  logic [5:0] expQueue [$];
  logic [4:0] modelData = 5'h00;

  sbox dut (
    .clock_i (clock),
    .reset_i (reset),
    .valid_i (validIn),
    .sbox_i  (sboxIn),
`ifdef SBOX_INV_EN
    .inv_i   (invIn),
`endif
    .valid_o (validOut),
    .sbox_o  (sboxOut)
  );

  // Free-running 10 ns clock.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Pops one scoreboard entry and compares it against the registered outputs.
  task automatic checkOutput(input string tag);
    logic [5:0] exp;
    checks++;
    assert (expQueue.size() != 0) else begin
      errors++;
      $error("[TB] FAIL %s: scoreboard empty, observed %b/%h", tag, validOut, sboxOut);
    end
    if (expQueue.size() != 0) begin
      exp = expQueue.pop_front();
      assert (validOut === exp[5]) else begin
        errors++;
        $error("[TB] FAIL %s valid: observed %b expected %b", tag, validOut, exp[5]);
      end
      checks++;
      assert (sboxOut === exp[4:0]) else begin
        errors++;
        $error("[TB] FAIL %s data: observed %h expected %h", tag, sboxOut, exp[4:0]);
      end
    end
  endtask

  // Drives one cycle, pushes the model's expectation, then checks #1 after
  // the edge.
  task automatic applyStimulus(input logic rst, input logic vld,
                               input logic [4:0] din, input logic inv,
                               input string tag);
    logic expValid;
    if (rst) begin
      modelData = 5'h00;
      expValid  = 1'b0;
    end else begin
      expValid = vld;
      if (vld) modelData = inv ? invRef[din] : fwdRef[din];
    end
    expQueue.push_back({expValid, modelData});
    reset   = rst;
    validIn = vld;
    sboxIn  = din;
    invIn   = inv;
    @(posedge clock);
    #1;
    checkOutput(tag);
  endtask

  initial begin
    logic [4:0] fwdOut;
    reset   = 1'b1;
    validIn = 1'b0;
    sboxIn  = 5'h00;
    invIn   = 1'b0;
    @(negedge clock);

    // Reset held with a valid input that must be dropped.
    applyStimulus(1'b1, 1'b1, 5'h1F, 1'b0, "reset0");
    applyStimulus(1'b1, 1'b1, 5'h1F, 1'b0, "reset1");

    // Exhaustive forward sweep, back-to-back; first valid right after reset.
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b0, 1'b1, 5'(i), 1'b0, $sformatf("sweep%02h", i));
    end

    // Hold: data stays, valid drops.
    applyStimulus(1'b0, 1'b1, 5'h03, 1'b0, "holdLoad");
    applyStimulus(1'b0, 1'b0, 5'h10, 1'b0, "hold1");
    applyStimulus(1'b0, 1'b0, 5'h10, 1'b0, "hold2");

    // Mid-stream reset drops the 0x06 column.
    applyStimulus(1'b0, 1'b1, 5'h05, 1'b0, "mid05");
    applyStimulus(1'b1, 1'b1, 5'h06, 1'b0, "mid06rst");
    applyStimulus(1'b0, 1'b1, 5'h07, 1'b0, "mid07");

`ifdef SBOX_INV_EN
    // Inverse spot checks.
    applyStimulus(1'b0, 1'b1, 5'h04, 1'b1, "inv04");
    applyStimulus(1'b0, 1'b1, 5'h17, 1'b1, "inv17");

    // Round trip: feed the DUT's forward image back through the inverse.
    for (int x = 0; x < 32; x++) begin
      applyStimulus(1'b0, 1'b1, 5'(x), 1'b0, $sformatf("rtFwd%02h", x));
      fwdOut = sboxOut;
      applyStimulus(1'b0, 1'b1, fwdOut, 1'b1, $sformatf("rtInv%02h", x));
      checks++;
      assert (sboxOut === 5'(x)) else begin
        errors++;
        $error("[TB] FAIL roundTrip%02h: observed %h expected %h", x, sboxOut, 5'(x));
      end
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sbox.md
# sbox

Ascon 5-bit substitution box, one registered column slice of the permutation's substitution layer (p_S). It maps one 5-bit column `sbox_i` to its Ascon S-box image and presents it on `sbox_o` one clock later. The block sits inside the substitution layer, which instantiates 64 copies, one per bit column of the 320-bit state.

## Interface
- No parameters.
- `clock_i`  in  1  rising-edge clock.
- `reset_i`  in  1  synchronous, active-high reset.
- `valid_i`  in  1  `sbox_i` carries a column to substitute this cycle.
- `sbox_i`  in  5  input column; bit 4 = x0 (state word 0), bit 0 = x4.
- `valid_o`  out  1  `sbox_o` holds a fresh result.
- `sbox_o`  out  5  substituted column, same bit ordering as `sbox_i`.
- `inv_i`  in  1  present only with `SBOX_INV_EN`; 1 selects the inverse S-box.
- One clock; reset is synchronous and active-high.

## Operation
- Forward map S(x), listed for x = 0x00..0x1F in order: 04 0B 1F 14 1A 15 09 02 1B 05 08 12 1D 03 06 1C 1E 13 07 0E 00 0D 11 18 10 0C 01 19 16 0A 0F 17.
- `sbox_o`: on a clock edge where `valid_i` = 1, the register loads S(`sbox_i`).
  - Otherwise it holds its previous value.
  - `valid_o` loads `valid_i` on every edge.
- Lookup is purely combinational ahead of the output register. There is no FSM.
- No back-pressure. A new input is accepted on every cycle.

## Timing
- Latency is exactly 1 cycle: input sampled at edge N appears on `sbox_o`/`valid_o` after edge N.
- Throughput is 1 column per cycle. Back-to-back `valid_i` produces back-to-back `valid_o`.
- Reset has priority over `valid_i`. At an edge where `reset_i` = 1:
  - `sbox_o` = 5'h00.
  - `valid_o` = 0.
- An input presented during reset is dropped.
- After reset deasserts, the first `valid_i` is honoured on that same edge.
- All 32 input codes are legal. There are no X outputs for defined inputs.

## Configuration
- Macro `SBOX_INV_EN`.
- When defined:
  - Port `inv_i` exists.
  - With `inv_i` = 1, the register loads S⁻¹(`sbox_i`).
  - S⁻¹ for x = 0x00..0x1F in order: 14 1A 07 0D 00 09 0E 12 0A 06 1D 01 19 15 13 1E 18 16 0B 11 03 05 1C 1F 17 1B 04 08 0F 0C 10 02.
  - `inv_i` is sampled alongside `valid_i` and has the same latency.
- When undefined: no `inv_i` port, forward map only, and no inverse table is synthesised.

## Structure
- Package `ascon_pack` holds:
  - the 32-entry 5-bit constant arrays `SBOX_TABLE` and `SBOX_INV_TABLE`; the inverse is guarded by `SBOX_INV_EN`;
  - a `sbox_col_t` 5-bit typedef.
- No sub-module: the table index plus one `always_ff` register is the whole block.

## Test plan
- Reset: hold `reset_i` = 1 with `valid_i` = 1, `sbox_i` = 0x1F -> `sbox_o` = 0x00, `valid_o` = 0.
- Exhaustive sweep: `valid_i` = 1, `sbox_i` = 0x00..0x1F on consecutive cycles -> one cycle later `sbox_o` follows the forward map; spot checks 0x00->0x04, 0x0A->0x08, 0x14->0x00, 0x1F->0x17; `valid_o` stays 1 throughout.
- Hold: load 0x03 (-> 0x14), then `valid_i` = 0 with `sbox_i` = 0x10 -> `sbox_o` stays 0x14 and `valid_o` = 0.
- Mid-stream reset: stream 0x05, 0x06, 0x07 and assert `reset_i` on the 0x06 edge -> outputs 0x15, then 0x00 with `valid_o` = 0, then 0x02.
- `SBOX_INV_EN` build:
  - `inv_i` = 1, `sbox_i` = 0x04 -> 0x00; `sbox_i` = 0x17 -> 0x1F.
  - Round trip: S⁻¹(S(x)) = x for all 32 x.
